// File: rtl/axis_join_pkg.sv
// Shared defaults and m_user packing for the weights/pixel stream join.
// tuser_st is the legacy default-width view of m_user (pixel user at the MSBs).
package axis_join_pkg;

  localparam int          CFG_BIT_DEF   = 0;
  localparam logic [15:0] GATE_MASK_DEF = 16'hFFF0;
  localparam int          W_USER_W_DEF  = 16;
  localparam int          P_USER_W_DEF  = 3;

  // m_user = {pixel user of stream 0, gated weights user}
  localparam int M_USER_W_LSB = 0;

  function automatic int m_user_p_lsb(input int w_user_w);
    return w_user_w;
  endfunction

  typedef struct packed {
    logic [P_USER_W_DEF-1:0] pix;
    logic [W_USER_W_DEF-1:0] w;
  } tuser_st;

  function automatic tuser_st tuser_unpack(input logic [P_USER_W_DEF+W_USER_W_DEF-1:0] flat);
    return tuser_st'(flat);
  endfunction

  function automatic logic [P_USER_W_DEF+W_USER_W_DEF-1:0] tuser_pack(input tuser_st t);
    return t;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Generic 2-entry registered skid buffer: s_ready depends only on flop state,
// so there is no combinational path from m_ready back to s_ready.
module axis_skid2 #(
  parameter int DATA_W = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic              main_full_q, main_full_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              drain;
  logic              push;

  assign s_ready = !skid_full_q;
  assign m_valid = main_full_q;
  assign m_data  = main_data_q;
  assign drain   = main_full_q && m_ready;
  assign push    = s_valid && !skid_full_q;

  always_comb begin
    main_full_d = main_full_q;
    skid_full_d = skid_full_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (drain) begin
      // skid full implies no push this cycle, so skid always refills main first
      if (skid_full_q) begin
        main_data_d = skid_data_q;
        skid_full_d = 1'b0;
      end else if (push) begin
        main_data_d = s_data;
      end else begin
        main_full_d = 1'b0;
      end
    end else if (push) begin
      if (!main_full_q) begin
        main_data_d = s_data;
        main_full_d = 1'b1;
      end else begin
        skid_data_d = s_data;
        skid_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      main_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_full_q <= main_full_d;
      skid_full_q <= skid_full_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/axis_stream_join.sv
// Joins one weights stream with N_PIX pixel streams into one beat-aligned,
// fully registered output; config beats bypass the pixel streams.
module axis_stream_join
  import axis_join_pkg::*;
#(
  parameter int                  N_PIX      = 2,
  parameter int                  WORD_WIDTH = 8,
  parameter int                  ROWS       = 8,
  parameter int                  COLS       = 24,
  parameter int                  W_USER_W   = 16,
  parameter int                  P_USER_W   = 3,
  parameter int                  CFG_BIT    = CFG_BIT_DEF,
  parameter logic [W_USER_W-1:0] GATE_MASK  = W_USER_W'(GATE_MASK_DEF),
  parameter int                  CNT_W      = 32
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             s_w_valid,
  output logic                             s_w_ready,
  input  logic                             s_w_last,
  input  logic [COLS*WORD_WIDTH-1:0]       s_w_data,
  input  logic [W_USER_W-1:0]              s_w_user,
  input  logic [N_PIX-1:0]                 s_p_valid,
  output logic [N_PIX-1:0]                 s_p_ready,
  input  logic [N_PIX-1:0]                 s_p_last,
  input  logic [N_PIX*ROWS*WORD_WIDTH-1:0] s_p_data,
  input  logic [N_PIX*P_USER_W-1:0]        s_p_user,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic [COLS*WORD_WIDTH-1:0]       m_w_data,
  output logic [N_PIX*ROWS*WORD_WIDTH-1:0] m_p_data,
  output logic [W_USER_W+P_USER_W-1:0]     m_user,
  input  logic                             clr_stats,
  output logic                             err_last,
  output logic [CNT_W-1:0]                 beat_cnt
);

  localparam int WD_W   = COLS*WORD_WIDTH;
  localparam int PD_W   = N_PIX*ROWS*WORD_WIDTH;
  localparam int ENT_W  = 1 + P_USER_W + W_USER_W + PD_W + WD_W;
  localparam int WU_LSB = WD_W + PD_W;
  localparam int PU_LSB = WU_LSB + W_USER_W;
  localparam int MU_P   = m_user_p_lsb(W_USER_W);

  logic                 cfg;
  logic                 slot_ok;
  logic                 pix_all;
  logic                 fire;
  logic                 mismatch;
  logic [P_USER_W-1:0]  p_user_cap;
  logic [PD_W-1:0]      p_data_cap;
  logic [ENT_W-1:0]     ent_in;
  logic [ENT_W-1:0]     ent_out;
  logic [W_USER_W-1:0]  w_user_out;
  logic                 err_last_q, err_last_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 unused_pix_user;

  assign cfg       = s_w_user[CFG_BIT];
  assign pix_all   = &s_p_valid;
  assign s_w_ready = slot_ok && (cfg || pix_all);
  assign fire      = s_w_valid && s_w_ready;

  // each pixel ready ignores its own valid so ready never waits on valid
  for (genvar i = 0; i < N_PIX; i++) begin : g_p_ready
    assign s_p_ready[i] = slot_ok && s_w_valid && !cfg &&
                          (&(s_p_valid | (N_PIX'(1) << i)));
  end

  assign p_user_cap      = cfg ? '0 : s_p_user[P_USER_W-1:0];
  assign p_data_cap      = cfg ? '0 : s_p_data;
  assign ent_in          = {s_w_last, p_user_cap, s_w_user, p_data_cap, s_w_data};
  assign unused_pix_user = ^s_p_user;

  axis_skid2 #(.DATA_W(ENT_W)) u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .s_valid (fire),
    .s_ready (slot_ok),
    .s_data  (ent_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (ent_out)
  );

  assign m_last     = ent_out[ENT_W-1];
  assign m_w_data   = ent_out[0 +: WD_W];
  assign m_p_data   = ent_out[WD_W +: PD_W];
  assign w_user_out = ent_out[WU_LSB +: W_USER_W];

  assign m_user[MU_P +: P_USER_W]         = ent_out[PU_LSB +: P_USER_W];
  assign m_user[M_USER_W_LSB +: W_USER_W] = (w_user_out & ~GATE_MASK) |
                                            (w_user_out & GATE_MASK & {W_USER_W{m_valid}});

  always_comb begin
    mismatch   = ((s_p_last != '0) && (s_p_last != '1)) || ((|s_p_last) && !s_w_last);
    err_last_d = err_last_q;
    if (fire && !cfg && mismatch) err_last_d = 1'b1;
    if (clr_stats)                err_last_d = 1'b0;
    beat_cnt_d = clr_stats ? '0 : beat_cnt_q + CNT_W'(m_valid && m_ready);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_last_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      err_last_q <= err_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign err_last = err_last_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_axis_stream_join.sv
// Directed and random stimulus for axis_stream_join checked against a
// queue-based reference of the join, two-deep buffering and stats.
module tb_axis_stream_join;

  localparam int N_PIX = 2;
  localparam int WD_W  = 192;
  localparam int PD_W  = 128;
  localparam int WU    = 16;
  localparam int PU    = 3;

  logic              aclk;
  logic              areset;
  logic              s_w_valid;
  logic              s_w_ready;
  logic              s_w_last;
  logic [WD_W-1:0]   s_w_data;
  logic [WU-1:0]     s_w_user;
  logic [N_PIX-1:0]  s_p_valid;
  logic [N_PIX-1:0]  s_p_ready;
  logic [N_PIX-1:0]  s_p_last;
  logic [PD_W-1:0]   s_p_data;
  logic [N_PIX*PU-1:0] s_p_user;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [WD_W-1:0]   m_w_data;
  logic [PD_W-1:0]   m_p_data;
  logic [WU+PU-1:0]  m_user;
  logic              clr_stats;
  logic              err_last;
  logic [31:0]       beat_cnt;

  axis_stream_join dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_w_valid (s_w_valid),
    .s_w_ready (s_w_ready),
    .s_w_last  (s_w_last),
    .s_w_data  (s_w_data),
    .s_w_user  (s_w_user),
    .s_p_valid (s_p_valid),
    .s_p_ready (s_p_ready),
    .s_p_last  (s_p_last),
    .s_p_data  (s_p_data),
    .s_p_user  (s_p_user),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_w_data  (m_w_data),
    .m_p_data  (m_p_data),
    .m_user    (m_user),
    .clr_stats (clr_stats),
    .err_last  (err_last),
    .beat_cnt  (beat_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic            last;
    logic [PU-1:0]   pu;
    logic [WU-1:0]   wu;
    logic [PD_W-1:0] pd;
    logic [WD_W-1:0] wd;
  } beat_t;

  beat_t       q[$];
  beat_t       nb;
  int unsigned cnt_m;
  logic        err_m;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    s_w_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s_p_data = {$urandom, $urandom, $urandom, $urandom};
    s_p_user = 6'($urandom);
    s_w_user = 16'($urandom) & 16'hFFFE;
  endtask

  // One clock: check everything against the reference, then advance it.
  task automatic cycle();
    logic             cfg, room, e_wr, fire, mis;
    logic [N_PIX-1:0] e_pr;
    @(negedge aclk);
    cfg  = s_w_user[0];
    room = q.size() < 2;
    e_wr = room && (cfg || (s_p_valid == 2'b11));
    for (int i = 0; i < N_PIX; i++)
      e_pr[i] = room && s_w_valid && !cfg && ((s_p_valid | (2'b01 << i)) == 2'b11);
    chk("s_w_ready", s_w_ready, e_wr);
    chk("s_p_ready", s_p_ready, e_pr);
    chk("m_valid", m_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_w_data", m_w_data, q[0].wd);
      chk("m_p_data", m_p_data, q[0].pd);
      chk("m_user", m_user, {q[0].pu, q[0].wu});
      chk("m_last", m_last, q[0].last);
    end else begin
      chk("gated_user", m_user[WU-1:0] & 16'hFFF0, 16'h0);
    end
    chk("beat_cnt", beat_cnt, cnt_m);
    chk("err_last", err_last, err_m);
    fire = s_w_valid && e_wr;
    if (q.size() != 0 && m_ready) begin
      void'(q.pop_front());
      cnt_m++;
    end
    if (fire) begin
      nb.last = s_w_last;
      nb.pu   = cfg ? '0 : s_p_user[PU-1:0];
      nb.wu   = s_w_user;
      nb.pd   = cfg ? '0 : s_p_data;
      nb.wd   = s_w_data;
      q.push_back(nb);
      mis = (s_p_last == 2'b01) || (s_p_last == 2'b10) || (s_p_last != 0 && !s_w_last);
      if (!cfg && mis) err_m = 1'b1;
    end
    if (clr_stats) begin
      cnt_m = 0;
      err_m = 1'b0;
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset = 1'b1; clr_stats = 1'b0; m_ready = 1'b0;
    s_w_valid = 1'b0; s_w_last = 1'b0; s_w_data = '0; s_w_user = '0;
    s_p_valid = '0; s_p_last = '0; s_p_data = '0; s_p_user = '0;
    cnt_m = 0; err_m = 1'b0;

    // reset values
    #3;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_w_data", m_w_data, '0);
    chk("rst_m_p_data", m_p_data, '0);
    chk("rst_m_user", m_user, '0);
    chk("rst_err_last", err_last, 1'b0);
    chk("rst_beat_cnt", beat_cnt, '0);
    s_w_valid = 1'b1; s_p_valid = 2'b11;
    #1;
    chk("rst_s_w_ready", s_w_ready, 1'b1);
    chk("rst_s_p_ready", s_p_ready, 2'b11);
    s_w_valid = 1'b0; s_p_valid = 2'b00;
    @(posedge aclk); #1;
    areset = 1'b0;

    // basic join, continuous m_ready
    m_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      rand_data();
      if (b == 0) begin
        s_p_data[7:0] = 8'hA1; s_p_data[71:64] = 8'hB1; s_w_data[7:0] = 8'h11;
      end
      s_w_valid = 1'b1; s_p_valid = 2'b11;
      s_w_last = (b == 5); s_p_last = (b == 5) ? 2'b11 : 2'b00;
      cycle();
    end
    s_w_valid = 1'b0; s_p_valid = 2'b00; s_w_last = 1'b0; s_p_last = 2'b00;
    repeat (3) cycle();

    // config bypass with pixel streams idle
    for (int b = 0; b < 3; b++) begin
      rand_data();
      s_w_user[0] = 1'b1;
      s_w_valid = 1'b1; s_p_valid = 2'b00; s_w_last = (b == 2);
      cycle();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0;
    repeat (2) cycle();

    // stream 1 stalls for 5 cycles, then releases
    rand_data();
    s_w_valid = 1'b1; s_p_valid = 2'b01;
    repeat (5) cycle();
    s_p_valid = 2'b11;
    for (int b = 0; b < 3; b++) begin
      cycle();
      rand_data();
    end
    s_w_valid = 1'b0; s_p_valid = 2'b00;
    repeat (3) cycle();

    // backpressure: m_ready low 4 cycles mid-stream
    s_w_valid = 1'b1; s_p_valid = 2'b11;
    rand_data(); cycle();
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rand_data(); cycle();
    end
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rand_data(); cycle();
    end
    s_w_valid = 1'b0; s_p_valid = 2'b00;
    repeat (3) cycle();

    // tlast mismatch, sticky, then clear (clear collides with a handshake)
    rand_data();
    s_w_valid = 1'b1; s_p_valid = 2'b11; s_w_last = 1'b1; s_p_last = 2'b01;
    cycle();
    s_w_valid = 1'b0; s_p_valid = 2'b00; s_w_last = 1'b0; s_p_last = 2'b00;
    clr_stats = 1'b0;
    repeat (3) cycle();
    rand_data();
    s_w_valid = 1'b1; s_p_valid = 2'b11;
    cycle();
    s_w_valid = 1'b0; s_p_valid = 2'b00;
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    repeat (2) cycle();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      rand_data();
      s_w_user[0] = ($urandom_range(0, 7) == 0);
      s_w_valid   = ($urandom_range(0, 3) != 0);
      s_p_valid   = 2'($urandom);
      s_w_last    = 1'($urandom);
      s_p_last    = ($urandom_range(0, 9) == 0) ? 2'($urandom) : {2{s_w_last}};
      m_ready     = ($urandom_range(0, 3) != 0);
      clr_stats   = ($urandom_range(0, 40) == 0);
      cycle();
    end
    clr_stats = 1'b0;

    // async reset with both entries full
    s_w_user[0] = 1'b0; s_w_valid = 1'b1; s_p_valid = 2'b11; s_p_last = 2'b00; s_w_last = 1'b0;
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    for (int b = 0; b < 4 && q.size() < 2; b++) begin
      rand_data(); cycle();
    end
    chk("pre_rst_m_valid", m_valid, 1'b1);
    areset = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_beat_cnt", beat_cnt, '0);
    chk("arst_m_user", m_user, '0);
    chk("arst_s_w_ready", s_w_ready, 1'b1);
    q.delete(); cnt_m = 0; err_m = 1'b0;
    #1;
    areset = 1'b0;
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rand_data(); cycle();
    end
    s_w_valid = 1'b0; s_p_valid = 2'b00;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
